// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback merge unit.
package wb_pkg;

  localparam int WB_SRC_PIPE = 0;
  localparam int WB_DW       = 32;
  localparam int WB_AW       = 5;

  // One buffered accelerator result at the default port widths.
  typedef struct packed {
    logic [WB_AW-1:0] regAddr;
    logic [WB_DW-1:0] data;
  } wbEntry_t;

  function automatic int src_w(input int numAcc);
    return $clog2(numAcc + 1);
  endfunction

endpackage

// File: rtl/wb_acc_fifo.sv
// Per-channel result FIFO: synchronous push/pop, registered occupancy count.
module wb_acc_fifo #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] pushData,
  input  logic [AW-1:0] pushReg,
  output logic [DW-1:0] popData,
  output logic [AW-1:0] popReg,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [AW+DW-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [PW:0]      count;
  logic             doPush;
  logic             doPop;

  assign full   = (count == (PW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign {popReg, popData} = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; a flush only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= {pushReg, pushData};
  end

endmodule

// File: rtl/wb_merge_unit.sv
// Writeback merge: pipeline writes win, buffered accelerator results drain round-robin.
module wb_merge_unit
  import wb_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NUM_ACC = 2,
  parameter int DEPTH   = 4
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [DW-1:0]               MEM_WB_ReadData,
  input  logic [DW-1:0]               MEM_WB_ALUResult,
  input  logic                        MEM_WB_MemtoReg,
  input  logic                        MEM_WB_RegWrite,
  input  logic [AW-1:0]               MEM_WB_WriteReg,
  input  logic [NUM_ACC-1:0]          acc_valid,
  input  logic [NUM_ACC*DW-1:0]       acc_data,
  input  logic [NUM_ACC*AW-1:0]       acc_reg,
  output logic [NUM_ACC-1:0]          acc_ready,
  output logic [DW-1:0]               WB_WriteData,
  output logic [AW-1:0]               WB_WriteReg,
  output logic                        WB_RegWrite,
  output logic [src_w(NUM_ACC)-1:0]   WB_Source,
  output logic                        acc_pending
);

  localparam int SW    = src_w(NUM_ACC);
  localparam int PTR_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

  logic [NUM_ACC-1:0] fifoFull;
  logic [NUM_ACC-1:0] fifoEmpty;
  logic [NUM_ACC-1:0] push;
  logic [NUM_ACC-1:0] pop;
  logic [DW-1:0]      popData [NUM_ACC];
  logic [AW-1:0]      popReg  [NUM_ACC];
  logic               slotTaken;
  logic               grantValid;
  logic [PTR_W-1:0]   grantIdx;
  logic [PTR_W-1:0]   rrPtr;

  assign slotTaken   = MEM_WB_RegWrite && (MEM_WB_WriteReg != '0);
  assign acc_ready   = ~fifoFull;
  assign push        = acc_valid & acc_ready;
  assign acc_pending = |(~fifoEmpty);

  for (genvar c = 0; c < NUM_ACC; c++) begin : gAcc
    wb_acc_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) uFifo (
      .clk      (Clk),
      .rst      (Reset),
      .push     (push[c]),
      .pop      (pop[c]),
      .pushData (acc_data[c*DW +: DW]),
      .pushReg  (acc_reg[c*AW +: AW]),
      .popData  (popData[c]),
      .popReg   (popReg[c]),
      .full     (fifoFull[c]),
      .empty    (fifoEmpty[c])
    );
  end

  // First non-empty channel at or after the round-robin pointer.
  always_comb begin
    int idx;
    idx        = 0;
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < NUM_ACC; k++) begin
      idx = (int'(rrPtr) + k) % NUM_ACC;
      if (!grantValid && !fifoEmpty[PTR_W'(idx)]) begin
        grantValid = 1'b1;
        grantIdx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (!slotTaken && grantValid) pop[grantIdx] = 1'b1;
  end

  // Output register stage
  always_ff @(posedge Clk) begin
    if (Reset) begin
      WB_RegWrite  <= 1'b0;
      WB_WriteReg  <= '0;
      WB_WriteData <= '0;
      WB_Source    <= '0;
      rrPtr        <= '0;
    end else if (slotTaken) begin
      WB_RegWrite  <= 1'b1;
      WB_WriteReg  <= MEM_WB_WriteReg;
      WB_WriteData <= MEM_WB_MemtoReg ? MEM_WB_ReadData : MEM_WB_ALUResult;
      WB_Source    <= SW'(WB_SRC_PIPE);
    end else if (grantValid) begin
      WB_RegWrite  <= (popReg[grantIdx] != '0);
      WB_WriteReg  <= popReg[grantIdx];
      WB_WriteData <= popData[grantIdx];
      WB_Source    <= SW'(grantIdx) + 1'b1;
      rrPtr        <= (grantIdx == PTR_W'(NUM_ACC - 1)) ? '0 : grantIdx + 1'b1;
    end else begin
      WB_RegWrite  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_merge_unit.sv
// Bench for wb_merge_unit: directed scenarios plus random traffic against a queue model.
module tb_wb_merge_unit;
  import wb_pkg::*;

  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int NUM_ACC = 2;
  localparam int DEPTH   = 4;

  logic                  Clk;
  logic                  Reset;
  logic [DW-1:0]         MEM_WB_ReadData;
  logic [DW-1:0]         MEM_WB_ALUResult;
  logic                  MEM_WB_MemtoReg;
  logic                  MEM_WB_RegWrite;
  logic [AW-1:0]         MEM_WB_WriteReg;
  logic [NUM_ACC-1:0]    acc_valid;
  logic [NUM_ACC*DW-1:0] acc_data;
  logic [NUM_ACC*AW-1:0] acc_reg;
  logic [NUM_ACC-1:0]    acc_ready;
  logic [DW-1:0]         WB_WriteData;
  logic [AW-1:0]         WB_WriteReg;
  logic                  WB_RegWrite;
  logic [1:0]            WB_Source;
  logic                  acc_pending;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per channel plus the expected output register.
  wbEntry_t   mq [NUM_ACC][$];
  int         mrr;
  logic       expWe;
  logic [4:0] expReg;
  logic [31:0] expData;
  logic [1:0] expSrc;

  wb_merge_unit #(.DW(DW), .AW(AW), .NUM_ACC(NUM_ACC), .DEPTH(DEPTH)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .MEM_WB_ReadData  (MEM_WB_ReadData),
    .MEM_WB_ALUResult (MEM_WB_ALUResult),
    .MEM_WB_MemtoReg  (MEM_WB_MemtoReg),
    .MEM_WB_RegWrite  (MEM_WB_RegWrite),
    .MEM_WB_WriteReg  (MEM_WB_WriteReg),
    .acc_valid        (acc_valid),
    .acc_data         (acc_data),
    .acc_reg          (acc_reg),
    .acc_ready        (acc_ready),
    .WB_WriteData     (WB_WriteData),
    .WB_WriteReg      (WB_WriteReg),
    .WB_RegWrite      (WB_RegWrite),
    .WB_Source        (WB_Source),
    .acc_pending      (acc_pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic modelStep();
    logic [NUM_ACC-1:0] accept;
    wbEntry_t e;
    bit found;
    if (Reset) begin
      for (int c = 0; c < NUM_ACC; c++) mq[c].delete();
      mrr = 0; expWe = 0; expReg = 0; expData = 0; expSrc = 0;
      return;
    end
    for (int c = 0; c < NUM_ACC; c++)
      accept[c] = acc_valid[c] && (mq[c].size() < DEPTH);
    if (MEM_WB_RegWrite && MEM_WB_WriteReg != 0) begin
      expWe   = 1;
      expReg  = MEM_WB_WriteReg;
      expData = MEM_WB_MemtoReg ? MEM_WB_ReadData : MEM_WB_ALUResult;
      expSrc  = 0;
    end else begin
      found = 0;
      for (int k = 0; k < NUM_ACC; k++) begin
        int c;
        c = (mrr + k) % NUM_ACC;
        if (!found && mq[c].size() > 0) begin
          found   = 1;
          e       = mq[c].pop_front();
          expWe   = (e.regAddr != 0);
          expReg  = e.regAddr;
          expData = e.data;
          expSrc  = 2'(c + 1);
          mrr     = (c + 1) % NUM_ACC;
        end
      end
      if (!found) expWe = 0;
    end
    for (int c = 0; c < NUM_ACC; c++) begin
      if (accept[c]) begin
        e.regAddr = acc_reg[c*AW +: AW];
        e.data    = acc_data[c*DW +: DW];
        mq[c].push_back(e);
      end
    end
  endtask

  task automatic tick();
    logic [NUM_ACC-1:0] expReady;
    logic expPend;
    modelStep();
    @(posedge Clk);
    #1;
    expPend = 0;
    for (int c = 0; c < NUM_ACC; c++) begin
      expReady[c] = (mq[c].size() < DEPTH);
      if (mq[c].size() > 0) expPend = 1;
    end
    checkEq("we",      WB_RegWrite,  expWe);
    checkEq("wreg",    WB_WriteReg,  expReg);
    checkEq("wdata",   WB_WriteData, expData);
    checkEq("src",     WB_Source,    expSrc);
    checkEq("ready",   acc_ready,    expReady);
    checkEq("pending", acc_pending,  expPend);
  endtask

  task automatic idleAll();
    MEM_WB_RegWrite = 0; MEM_WB_WriteReg = 0; MEM_WB_MemtoReg = 0;
    MEM_WB_ReadData = 0; MEM_WB_ALUResult = 0;
    acc_valid = 0; acc_data = 0; acc_reg = 0;
  endtask

  task automatic pipeWrite(input logic [4:0] r, input logic [31:0] d);
    MEM_WB_RegWrite = 1; MEM_WB_WriteReg = r; MEM_WB_MemtoReg = 0;
    MEM_WB_ALUResult = d; MEM_WB_ReadData = ~d;
  endtask

  task automatic pipeIdle();
    MEM_WB_RegWrite = 0; MEM_WB_WriteReg = 0;
  endtask

  task automatic accPush(input int c, input logic [4:0] r, input logic [31:0] d);
    acc_valid[c] = 1;
    acc_reg[c*AW +: AW] = r;
    acc_data[c*DW +: DW] = d;
  endtask

  task automatic doReset();
    Reset = 1; tick(); Reset = 0;
  endtask

  initial begin
    logic [31:0] rrData [4];
    logic [1:0]  rrSrc  [4];
    Reset = 1;
    idleAll();
    tick(); tick();
    Reset = 0;

    // Reset with both FIFOs half full
    pipeWrite(1, 32'h100);
    accPush(0, 5'd4, 32'hA000_0001); accPush(1, 5'd6, 32'hB000_0001); tick();
    accPush(0, 5'd4, 32'hA000_0002); accPush(1, 5'd6, 32'hB000_0002); tick();
    idleAll();
    doReset();
    tick();
    checkEq("rst_we",      WB_RegWrite,  1'b0);
    checkEq("rst_wdata",   WB_WriteData, 32'h0);
    checkEq("rst_pending", acc_pending,  1'b0);
    checkEq("rst_ready",   acc_ready,    2'b11);

    // Pipeline-only load write
    MEM_WB_RegWrite = 1; MEM_WB_WriteReg = 8; MEM_WB_MemtoReg = 1;
    MEM_WB_ReadData = 32'hDEADBEEF; MEM_WB_ALUResult = 32'h1234_5678;
    tick();
    checkEq("pipe_we",    WB_RegWrite,  1'b1);
    checkEq("pipe_reg",   WB_WriteReg,  5'd8);
    checkEq("pipe_data",  WB_WriteData, 32'hDEADBEEF);
    checkEq("pipe_src",   WB_Source,    2'd0);

    // Collision: ch0 entry waits behind three pipeline writes
    idleAll();
    pipeWrite(3, 32'h33); accPush(0, 5'd9, 32'h11); tick();
    acc_valid = 0;
    pipeWrite(4, 32'h44); tick();
    pipeWrite(5, 32'h55); tick();
    checkEq("coll_pending", acc_pending, 1'b1);
    checkEq("coll_pipe",    WB_WriteReg, 5'd5);
    pipeIdle(); tick();
    checkEq("coll_we",   WB_RegWrite,  1'b1);
    checkEq("coll_reg",  WB_WriteReg,  5'd9);
    checkEq("coll_data", WB_WriteData, 32'h11);
    checkEq("coll_src",  WB_Source,    2'd1);

    // Round-robin between two loaded channels
    idleAll();
    doReset();
    rrData[0] = 32'hC0; rrData[1] = 32'hD0; rrData[2] = 32'hC1; rrData[3] = 32'hD1;
    rrSrc[0] = 1; rrSrc[1] = 2; rrSrc[2] = 1; rrSrc[3] = 2;
    pipeWrite(1, 32'h1);
    accPush(0, 5'd10, rrData[0]); accPush(1, 5'd20, rrData[1]); tick();
    accPush(0, 5'd11, rrData[2]); accPush(1, 5'd21, rrData[3]); tick();
    idleAll();
    for (int i = 0; i < 4; i++) begin
      tick();
      checkEq($sformatf("rr_src%0d", i),  WB_Source,    rrSrc[i]);
      checkEq($sformatf("rr_data%0d", i), WB_WriteData, rrData[i]);
    end

    // Fill ch1 while the pipeline always writes
    for (int i = 0; i < 4; i++) begin
      pipeWrite(5'(i + 1), 32'(i));
      accPush(1, 5'(12 + i), 32'hF00 + 32'(i));
      tick();
    end
    checkEq("full_ready", acc_ready[1], 1'b0);
    pipeWrite(7, 32'h7);
    accPush(1, 5'd16, 32'hF04); tick();
    checkEq("full_reject", acc_ready[1], 1'b0);
    pipeIdle(); tick();
    checkEq("full_pop_data", WB_WriteData, 32'hF00);
    checkEq("full_pop_src",  WB_Source,    2'd2);
    pipeWrite(8, 32'h8); tick();
    checkEq("full_refill", acc_ready[1], 1'b0);
    idleAll();
    for (int i = 0; i < 5; i++) tick();
    checkEq("full_drained", acc_pending, 1'b0);

    // $0 handling
    doReset();
    pipeWrite(1, 32'h1); accPush(0, 5'd7, 32'h7777); tick();
    acc_valid = 0;
    MEM_WB_RegWrite = 1; MEM_WB_WriteReg = 0; tick();
    checkEq("z_pipe_we",  WB_RegWrite, 1'b1);
    checkEq("z_pipe_reg", WB_WriteReg, 5'd7);
    checkEq("z_pipe_src", WB_Source,   2'd1);
    pipeWrite(2, 32'h2); accPush(0, 5'd0, 32'hE0E0); tick();
    idleAll(); tick();
    checkEq("z_acc_we",   WB_RegWrite,  1'b0);
    checkEq("z_acc_src",  WB_Source,    2'd1);
    checkEq("z_acc_data", WB_WriteData, 32'hE0E0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      Reset            = ($urandom_range(63) == 0);
      MEM_WB_RegWrite  = 1'($urandom_range(1));
      MEM_WB_WriteReg  = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
      MEM_WB_MemtoReg  = 1'($urandom_range(1));
      MEM_WB_ReadData  = $urandom;
      MEM_WB_ALUResult = $urandom;
      acc_valid        = 2'($urandom_range(3));
      acc_data         = {$urandom, $urandom};
      acc_reg          = 10'($urandom);
      tick();
    end
    Reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
